fetch_pc_unit: RTL and testbench

// - Fetch-stage PC owner. It consumes the redirect (taken branch, J, or JR target) resolved in Execute,

---
 rtl/fetch_pc_unit_if.sv | 33 +++
 rtl/fetch_pc_unit.sv | 76 +++++++
 tb/tb_fetch_pc_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: redirect, instruction-memory and decode-side signals of the fetch PC unit (perf counters under FETCH_PERF_CNT_EN)
interface fetch_pc_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] drop_cnt;
`endif
  modport master (
`ifdef FETCH_PERF_CNT_EN
    output redirect_cnt, drop_cnt,
`endif
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, flush
  );
  modport slave (
`ifdef FETCH_PERF_CNT_EN
    input  redirect_cnt, drop_cnt,
`endif
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, flush
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC owner with credit-limited imem requests, stale-response dropping and instruction queue; FETCH_PERF_CNT_EN adds counters
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int          FIFO_DEPTH = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_pc_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, resp_pc;
  logic [31:0]   q_instr [FIFO_DEPTH];
  logic [31:0]   q_pc [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, drop, inflight_next;
  logic          issue, push, pop, discard;
  always_comb begin
    bus.imem_req  = !rst_i && (inflight + count) < CW'(FIFO_DEPTH);
    issue         = bus.imem_req && bus.imem_gnt;
    discard       = bus.imem_rvalid && (drop != '0 || bus.redirect);
    push          = bus.imem_rvalid && drop == '0 && !bus.redirect;
    pop           = bus.instr_valid && bus.instr_ready && !bus.redirect;
    inflight_next = inflight + CW'(issue) - CW'(bus.imem_rvalid);
  end
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = count != '0;
  assign bus.instr       = q_instr[rd_ptr];
  assign bus.instr_pc    = q_pc[rd_ptr];
  assign bus.flush       = bus.redirect;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (bus.redirect) begin
        // everything still outstanding after this cycle belongs to the old path
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight_next;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_STEP;
        if (discard) drop <= drop - CW'(1);
        if (push) begin
          q_instr[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr]    <= resp_pc;
          wr_ptr          <= wr_ptr + AW'(1);
          resp_pc         <= resp_pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.redirect_cnt <= '0;
      bus.drop_cnt     <= '0;
    end else begin
      if (bus.redirect && bus.redirect_cnt != '1) bus.redirect_cnt <= bus.redirect_cnt + 32'd1;
      if (discard && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: random imem/decode/redirect stimulus against an epoch-based fetch model with a scoreboard monitor
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_pc_unit_if bus();
  fetch_pc_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [31:0] addr; int ep; int cyc; } req_t;
  exp_t sbq[$];
  req_t memq[$];
  int total = 0, bad = 0, cyc = 0, epoch = 0;
  int n_redir = 0, n_drop = 0;
  int p_gnt, p_rv, p_rdy, p_redir;
  logic [31:0] model_pc = 32'h0;
  bit pend_redir = 0, pend_push = 0;
  exp_t pend_e;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input bit next_rst);
    bit rv, redir, gnt;
    logic [31:0] tgt;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_redir) begin
      sbq.delete();
      epoch++;
    end else if (pend_push) sbq.push_back(pend_e);
    pend_redir = 0;
    pend_push  = 0;
    check("req", {31'b0, bus.imem_req}, {31'b0, !rst && (memq.size() + sbq.size() < 2)});
    if (bus.imem_req) check("addr", bus.imem_addr, model_pc);
    gnt   = $urandom_range(0, 99) < p_gnt;
    rv    = memq.size() > 0 && memq[0].cyc < cyc && $urandom_range(0, 99) < p_rv;
    redir = $urandom_range(0, 99) < p_redir;
    tgt   = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : ($urandom & 32'h0000_FFF0);
    if (next_rst) begin
      gnt = 0; rv = 0; redir = 0;
    end
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.redirect    = redir;
    bus.redirect_pc = tgt;
    bus.instr_ready = $urandom_range(0, 99) < p_rdy;
    bus.imem_rdata  = $urandom;
    if (rv) begin
      r = memq.pop_front();
      bus.imem_rdata = word(r.addr);
      if (!redir && r.ep == epoch) begin
        pend_push = 1;
        pend_e = '{r.addr, word(r.addr)};
      end else n_drop++;
    end
    if (bus.imem_req && gnt) begin
      memq.push_back('{model_pc, epoch, cyc});
      model_pc = model_pc + 32'd1;
    end
    if (redir) begin
      pend_redir = 1;
      model_pc = tgt;
      n_redir++;
    end
    rst = next_rst;
    if (next_rst) begin
      memq.delete();
      sbq.delete();
      pend_redir = 0;
      pend_push  = 0;
      model_pc   = 32'h0;
      epoch++;
      n_redir = 0;
      n_drop  = 0;
    end
  endtask
  task automatic phase(input int n, input int g, input int v, input int d, input int x);
    p_gnt = g; p_rv = v; p_rdy = d; p_redir = x;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("flush", {31'b0, bus.flush}, {31'b0, bus.redirect});
        check("valid", {31'b0, bus.instr_valid}, {31'b0, sbq.size() > 0});
        if (bus.instr_valid && bus.instr_ready && !bus.redirect && sbq.size() > 0) begin
          e = sbq.pop_front();
          check("instr_pc", bus.instr_pc, e.pc);
          check("instr", bus.instr, e.ins);
        end
      end
    end
  end
  initial begin
    bus.redirect = 0; bus.redirect_pc = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0;
    bus.imem_rdata = 0; bus.instr_ready = 0;
    p_gnt = 0; p_rv = 0; p_rdy = 0; p_redir = 0;
    repeat (3) step(1'b1);
    step(1'b0);
    phase(100, 100, 100, 100, 0);
    phase(30, 100, 100, 0, 0);
    phase(20, 100, 100, 100, 0);
    phase(10, 0, 100, 100, 0);
    phase(400, 70, 70, 70, 10);
    phase(200, 100, 100, 100, 30);
    phase(200, 50, 40, 50, 15);
    step(1'b1);
    step(1'b1);
    phase(300, 60, 60, 60, 8);
    phase(50, 100, 100, 100, 0);
`ifdef FETCH_PERF_CNT_EN
    check("redirect_cnt", bus.redirect_cnt, n_redir);
    check("drop_cnt", bus.drop_cnt, n_drop);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
